// File: rtl/led_pkg.sv
// -----------------------------------------------------------------------------
// led_pkg
//   Shared types and timing constants for the status-LED arbiter.
//   led_mode_e  : per-source display mode as presented on req_mode
//   arb_state_e : arbiter FSM state
//   *_HALF_MS   : half-period lengths (ms) for blink and breathe patterns
// -----------------------------------------------------------------------------
package led_pkg;

   typedef enum logic [1:0] {
      SOLID   = 2'b00,
      BLINK1  = 2'b01,
      BLINK4  = 2'b10,
      BREATHE = 2'b11
   } led_mode_e;

   typedef enum logic {
      IDLE = 1'b0,
      SHOW = 1'b1
   } arb_state_e;

   localparam int BLINK1_HALF_MS  = 500;
   localparam int BLINK4_HALF_MS  = 125;
   localparam int BREATHE_HALF_MS = 1000;

endpackage

// File: rtl/led_timebase.sv
// -----------------------------------------------------------------------------
// led_timebase
//   Free-running timebase for the status-LED arbiter.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     ms_tick    : one-clk pulse every CLK_HZ/1000 clocks
//     pwm_cnt    : PWM counter, free-running modulo 2^PWM_BITS
//     pwm_wrap   : high in the last count of each PWM period
// -----------------------------------------------------------------------------
module led_timebase #(
   parameter int CLK_HZ   = 12_000_000,
   parameter int PWM_BITS = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   output logic                ms_tick,
   output logic [PWM_BITS-1:0] pwm_cnt,
   output logic                pwm_wrap
);

   localparam int DIV   = CLK_HZ / 1000;
   localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

   logic [DIV_W-1:0] ms_cnt;

   assign ms_tick  = (ms_cnt == DIV_W'(DIV - 1));
   assign pwm_wrap = &pwm_cnt;

   // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ms_cnt  <= '0;
         pwm_cnt <= '0;
      end else begin
         ms_cnt  <= ms_tick ? '0 : ms_cnt + DIV_W'(1);
         pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      end
   end

endmodule

// File: rtl/led_status_arbiter.sv
// -----------------------------------------------------------------------------
// led_status_arbiter
//   Shares one common-anode RGB status LED among NUM_REQ sources. Fixed
//   priority (index 0 highest) with a minimum display time, per-grant latched
//   colour and mode, blink timing, global PWM brightness, active-low pins.
//   Ports:
//     clk, rst_n          : clock, asynchronous active-low reset
//     req[NUM_REQ]        : level request per source
//     req_rgb[3*NUM_REQ]  : {r,g,b} per source, source i at [3i+2:3i]
//     req_mode[2*NUM_REQ] : led_mode_e per source, source i at [2i+1:2i]
//     brightness          : global duty, taken at each PWM wrap
//     grant               : one-hot owner, zero when idle
//     busy                : |grant
//     led_red/green/blue  : registered active-low pad drives (1 = off)
//   Build option:
//     LED_BREATHE_EN : mode BREATHE ramps duty 0 -> brightness -> 0 over
//                      2 x 1000 ms; when undefined BREATHE shows as SOLID.
// -----------------------------------------------------------------------------
module led_status_arbiter
   import led_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int CLK_HZ      = 12_000_000,
   parameter int PWM_BITS    = 8,
   parameter int MIN_HOLD_MS = 100
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_REQ-1:0]    req,
   input  logic [3*NUM_REQ-1:0]  req_rgb,
   input  logic [2*NUM_REQ-1:0]  req_mode,
   input  logic [PWM_BITS-1:0]   brightness,
   output logic [NUM_REQ-1:0]    grant,
   output logic                  busy,
   output logic                  led_red,
   output logic                  led_green,
   output logic                  led_blue
);

   localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int HOLD_W = (MIN_HOLD_MS > 0) ? $clog2(MIN_HOLD_MS + 1) : 1;

   logic                ms_tick;
   logic [PWM_BITS-1:0] pwm_cnt;
   logic                pwm_wrap;

   led_timebase #(
      .CLK_HZ   (CLK_HZ),
      .PWM_BITS (PWM_BITS)
   ) u_timebase (
      .clk      (clk),
      .rst_n    (rst_n),
      .ms_tick  (ms_tick),
      .pwm_cnt  (pwm_cnt),
      .pwm_wrap (pwm_wrap)
   );

   arb_state_e          state;
   logic [IDX_W-1:0]    owner;
   logic [2:0]          lat_rgb;
   led_mode_e           lat_mode;
   logic [HOLD_W-1:0]   hold_ms;
   logic [8:0]          half_cnt;
   logic                blink_on;
   logic [PWM_BITS-1:0] brt_reg;

   logic [IDX_W-1:0]    top_idx;
   logic                any_req;
   logic                hold_met;
   logic                load;
   logic                drop;
   logic [8:0]          half_last;
   logic [PWM_BITS-1:0] duty;
   logic                blink_ok;
   logic [2:0]          lit;

`ifdef LED_BREATHE_EN
   localparam logic [10:0] PHASE_LAST = 11'(2 * BREATHE_HALF_MS - 1);
   localparam logic [10:0] RAMP_TOP   = 11'(BREATHE_HALF_MS);
   localparam logic [PWM_BITS+10:0] RAMP_DIV = (PWM_BITS + 11)'(BREATHE_HALF_MS);
   logic [10:0]          phase_ms;
   logic [10:0]          ramp;
   logic [PWM_BITS+10:0] prod;
`endif

   assign busy     = |grant;
   assign hold_met = (hold_ms == HOLD_W'(MIN_HOLD_MS));

   // Arbitration decision: load takes the best requester as a fresh grant,
   // drop returns to IDLE. Both only fire once the hold time is met in SHOW.
   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      top_idx = '0;
      any_req = |req;
      load    = 1'b0;
      drop    = 1'b0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req[i]) top_idx = IDX_W'(i);
      end
      if (state == IDLE) begin
         load = any_req;
      end else if (hold_met) begin
         if (!req[owner]) begin
            load = any_req;
            drop = !any_req;
         end else if (top_idx < owner) begin
            load = 1'b1;
         end
      end
   end

   assign half_last = (lat_mode == BLINK1) ? 9'(BLINK1_HALF_MS - 1) : 9'(BLINK4_HALF_MS - 1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         grant    <= '0;
         owner    <= '0;
         lat_rgb  <= '0;
         lat_mode <= SOLID;
         hold_ms  <= '0;
         half_cnt <= '0;
         blink_on <= 1'b0;
`ifdef LED_BREATHE_EN
         phase_ms <= '0;
`endif
      end else if (load) begin
         state    <= SHOW;
         grant    <= NUM_REQ'(1) << top_idx;
         owner    <= top_idx;
         lat_rgb  <= req_rgb[3*top_idx +: 3];
         lat_mode <= led_mode_e'(req_mode[2*top_idx +: 2]);
         hold_ms  <= '0;
         half_cnt <= '0;
         blink_on <= 1'b1;      // every pattern starts in its on-phase
`ifdef LED_BREATHE_EN
         phase_ms <= '0;
`endif
      end else if (drop) begin
         state <= IDLE;
         grant <= '0;
      end else if (state == SHOW && ms_tick) begin
         if (!hold_met) hold_ms <= hold_ms + HOLD_W'(1);
         if (half_cnt == half_last) begin
            half_cnt <= '0;
            blink_on <= !blink_on;
         end else begin
            half_cnt <= half_cnt + 9'd1;
         end
`ifdef LED_BREATHE_EN
         phase_ms <= (phase_ms == PHASE_LAST) ? '0 : phase_ms + 11'd1;
`endif
      end
   end

   // Duty and per-channel lit decision from registered state only.
   always_comb begin
      duty = brt_reg;
`ifdef LED_BREATHE_EN
      // Triangle 0..1000..0 over one 2000 ms period, scaled onto brightness.
      ramp = (phase_ms > RAMP_TOP) ? 11'(2 * BREATHE_HALF_MS) - phase_ms : phase_ms;
      prod = {11'd0, brt_reg} * {{PWM_BITS{1'b0}}, ramp};
      if (lat_mode == BREATHE) duty = PWM_BITS'(prod / RAMP_DIV);
`endif
      blink_ok = ((lat_mode != BLINK1) && (lat_mode != BLINK4)) || blink_on;
      lit      = (state == SHOW && blink_ok && (pwm_cnt < duty)) ? lat_rgb : 3'b000;
   end

   // brightness is only taken at the PWM wrap so a period never mixes two duties.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         brt_reg   <= '0;
         led_red   <= 1'b1;
         led_green <= 1'b1;
         led_blue  <= 1'b1;
      end else begin
         if (pwm_wrap) brt_reg <= brightness;
         led_red   <= ~lit[2];
         led_green <= ~lit[1];
         led_blue  <= ~lit[0];
      end
   end

endmodule

// File: tb/tb_led_status_arbiter.sv
// -----------------------------------------------------------------------------
// tb_led_status_arbiter
//   Self-checking bench for led_status_arbiter with CLK_HZ=16_000 (1 ms = 16
//   clk), PWM_BITS=4, MIN_HOLD_MS=4. A behavioural model tracks the owner and
//   the ms elapsed since grant as plain integers and predicts grant, busy and
//   the pins every cycle; directed scenarios add explicit checks.
// -----------------------------------------------------------------------------
module tb_led_status_arbiter;

   localparam int NUM_REQ    = 4;
   localparam int PWM_BITS   = 4;
   localparam int MIN_HOLD   = 4;
   localparam int MS_CLKS    = 16;
   localparam int PWM_LEVELS = 16;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic [NUM_REQ-1:0]    req;
   logic [3*NUM_REQ-1:0]  req_rgb;
   logic [2*NUM_REQ-1:0]  req_mode;
   logic [PWM_BITS-1:0]   brightness;
   logic [NUM_REQ-1:0]    grant;
   logic                  busy;
   logic                  led_red;
   logic                  led_green;
   logic                  led_blue;

   led_status_arbiter #(
      .NUM_REQ     (NUM_REQ),
      .CLK_HZ      (16_000),
      .PWM_BITS    (PWM_BITS),
      .MIN_HOLD_MS (MIN_HOLD)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        (req),
      .req_rgb    (req_rgb),
      .req_mode   (req_mode),
      .brightness (brightness),
      .grant      (grant),
      .busy       (busy),
      .led_red    (led_red),
      .led_green  (led_green),
      .led_blue   (led_blue)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input int unsigned got, input int unsigned exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int         m_cyc;     // clocks since reset release (drives ms and pwm timing)
   int         m_owner;   // -1 when idle
   int         m_hold;    // ms shown so far, saturating
   int         m_phase;   // ms since grant
   int         m_mode;
   int         m_brt;
   logic [2:0] m_rgb;
   logic [2:0] m_pins;

   task automatic model_reset();
      m_cyc   = 0;
      m_owner = -1;
      m_hold  = 0;
      m_phase = 0;
      m_mode  = 0;
      m_brt   = 0;
      m_rgb   = 3'b000;
      m_pins  = 3'b111;
   endtask

   function automatic int model_duty();
      int d;
      d = m_brt;
`ifdef LED_BREATHE_EN
      if (m_mode == 3) begin
         int p;
         p = m_phase % 2000;
         if (p > 1000) p = 2000 - p;
         d = m_brt * p / 1000;
      end
`endif
      return d;
   endfunction

   function automatic logic [2:0] model_lit(input int pwm);
      bit on;
      on = 1'b1;
      if (m_mode == 1) on = ((m_phase / 500) % 2) == 0;
      if (m_mode == 2) on = ((m_phase / 125) % 2) == 0;
      if (m_owner < 0 || !on || pwm >= model_duty()) return 3'b000;
      return m_rgb;
   endfunction

   task automatic model_grab(input int i);
      m_owner = i;
      m_hold  = 0;
      m_phase = 0;
      m_rgb   = req_rgb[3*i +: 3];
      m_mode  = int'(req_mode[2*i +: 2]);
   endtask

   task automatic model_step();
      int         top;
      int         pwm;
      bit         tick;
      logic [2:0] lit;
      pwm  = m_cyc % PWM_LEVELS;
      tick = (m_cyc % MS_CLKS) == MS_CLKS - 1;
      lit  = model_lit(pwm);
      top  = -1;
      for (int i = NUM_REQ - 1; i >= 0; i--) if (req[i]) top = i;
      if (m_owner < 0) begin
         if (top >= 0) model_grab(top);
      end else if (m_hold >= MIN_HOLD && (!req[m_owner] || top < m_owner)) begin
         if (top >= 0) model_grab(top);
         else m_owner = -1;
      end else if (tick) begin
         if (m_hold < MIN_HOLD) m_hold++;
         m_phase++;
      end
      if (pwm == PWM_LEVELS - 1) m_brt = int'(brightness);
      m_pins = ~lit;
      m_cyc++;
   endtask

   // One clock: model follows the edge, outputs compared on the falling edge.
   task automatic cycle();
      int exp_grant;
      @(posedge clk);
      if (rst_n) model_step();
      @(negedge clk);
      exp_grant = (m_owner < 0) ? 0 : (1 << m_owner);
      check("grant", grant, exp_grant);
      check("busy", busy, (m_owner >= 0) ? 1 : 0);
      check("pins", {led_red, led_green, led_blue}, m_pins);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int  lows;
      int  other_lows;
      int  cnt;
      bit  sw;
      bit  gap;

      rst_n      = 1'b0;
      req        = '0;
      req_rgb    = '0;
      req_mode   = '0;
      brightness = '0;
      model_reset();
      repeat (2) @(negedge clk);
      check("rst_grant", grant, 0);
      check("rst_busy", busy, 0);
      check("rst_pins", {led_red, led_green, led_blue}, 3'b111);
      rst_n      = 1'b1;
      brightness = 4'd15;
      repeat (20) cycle();

      // Reset while showing: outputs clear at once, stays idle afterwards.
      req_rgb[2:0] = 3'b111;
      req          = 4'b0001;
      repeat (10) cycle();
      check("pre_rst_busy", busy, 1);
      req   = '0;
      rst_n = 1'b0;
      #1;
      check("mid_rst_grant", grant, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_pins", {led_red, led_green, led_blue}, 3'b111);
      model_reset();
      cycle();
      rst_n = 1'b1;
      repeat (20) cycle();
      check("post_rst_idle", grant, 0);

      // Red solid at full brightness: grant next clk, pins the clk after.
      req_rgb[8:6] = 3'b100;
      req_mode     = '0;
      req          = 4'b0100;
      cycle();
      check("s2_grant", grant, 4'b0100);
      cycle();
      lows       = 0;
      other_lows = 0;
      repeat (16) begin
         if (!led_red) lows++;
         if (!led_green || !led_blue) other_lows++;
         cycle();
      end
      check("s2_red_low", lows, 15);
      check("s2_gb_low", other_lows, 0);

      // Higher priority arrives about 1 ms in: waits for the hold, no idle gap.
      req_rgb[2:0] = 3'b010;
      req          = 4'b0101;
      sw  = 1'b0;
      gap = 1'b0;
      for (int k = 0; k < 200 && !sw; k++) begin
         cycle();
         if (grant == 4'b0000) gap = 1'b1;
         if (grant == 4'b0001) sw = 1'b1;
      end
      check("s3_switch", sw, 1);
      check("s3_no_gap", gap, 0);
      req = '0;
      for (int k = 0; k < 200 && grant != 4'b0000; k++) cycle();
      check("s3_idle", grant, 0);

      // One-clock pulse is still shown for the full hold.
      req_rgb[5:3] = 3'b011;
      req          = 4'b0010;
      cycle();
      req = '0;
      cnt = 0;
      for (int k = 0; k < 200 && grant == 4'b0010; k++) begin
         cnt++;
         cycle();
      end
      check("s4_hold_len", (cnt >= 50 && cnt <= 65) ? 1 : 0, 1);
      check("s4_idle", grant, 0);
      cycle();
      check("s4_dark", {led_red, led_green, led_blue}, 3'b111);

      // 4 Hz blink: dark at brightness 0, half duty over one blink period at 8.
      req_rgb[11:9]  = 3'b111;
      req_mode[7:6]  = 2'b10;
      brightness     = 4'd0;
      req            = 4'b1000;
      repeat (40) cycle();
      lows = 0;
      repeat (4000) begin
         if (!led_red) lows++;
         cycle();
      end
      check("s5_dark", lows, 0);
      brightness = 4'd8;
      repeat (40) cycle();
      lows = 0;
      repeat (4000) begin
         if (!led_red) lows++;
         cycle();
      end
      check("s5_half", lows, 1000);

      // Breathe on blue: dark at grant when the ramp is built, else solid.
      req = '0;
      for (int k = 0; k < 200 && grant != 4'b0000; k++) cycle();
      check("s6_idle", grant, 0);
      brightness    = 4'd15;
      repeat (20) cycle();
      req_rgb[5:3]  = 3'b001;
      req_mode[3:2] = 2'b11;
      req           = 4'b0010;
      cycle();
      cycle();
      lows = 0;
      repeat (16) begin
         if (!led_blue) lows++;
         cycle();
      end
`ifdef LED_BREATHE_EN
      check("s6_start", lows, 0);
`else
      check("s6_start", lows, 15);
`endif
      repeat (32800) cycle();
      check("s6_grant", grant, 4'b0010);

      // Randomised traffic.
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(7) == 0) req = 4'($urandom);
         if ($urandom_range(15) == 0) begin
            req_rgb  = 12'($urandom);
            req_mode = 8'($urandom);
         end
         if ($urandom_range(63) == 0) brightness = 4'($urandom);
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
